sblk_ctrl: RTL and testbench

//   Control sequencer of one systolic block (sblk): accepts a packed loop instruction, fetches

---
 rtl/sblk_pkg.sv | 65 ++++++
 rtl/sblk_if.sv | 34 +++
 rtl/sblk_act_buf.sv | 43 ++++
 rtl/sblk_ctrl.sv | 160 ++++++++++++++++
 tb/tb_sblk_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sblk_pkg.sv
// ----------------------------------------------------------------------------
// sblk_pkg
//   Shared definitions for the systolic-block control sequencer: instruction
//   field widths, the packed loop instruction, the sequencer state encoding
//   and small helpers that derive loop bounds from a latched instruction.
//   No ports (package).
// ----------------------------------------------------------------------------
package sblk_pkg;

    localparam int N_TILE         = 4;
    localparam int WID_ACT        = 16;
    localparam int WID_ACTADDR    = 6;
    localparam int WID_INST_TN    = 4;
    localparam int WID_INST_TM    = 9;
    localparam int WID_INST_TP    = 5;
    localparam int WID_INST_LN    = 5;
    localparam int WID_INST_LP    = 5;
    localparam int WID_INST       = WID_INST_TN + WID_INST_TM + WID_INST_TP
                                  + WID_INST_LN + WID_INST_LP;
    localparam int WB_DELAY_CYCLE = N_TILE + 8;

    // Beat count n_tn*n_tp*N_TILE and compute count n_tm*n_tp never saturate,
    // so the counters are sized to hold the largest possible product.
    localparam int WID_NB    = WID_INST_TN + WID_INST_TP + $clog2(N_TILE);
    localparam int WID_NCOMP = WID_INST_TM + WID_INST_TP;
    localparam int WID_WB    = $clog2(WB_DELAY_CYCLE + 1);

    // n_tn sits in the LSBs of inst_data.
    typedef struct packed {
        logic [WID_INST_LP-1:0] lp;
        logic [WID_INST_LN-1:0] ln;
        logic [WID_INST_TP-1:0] tp;
        logic [WID_INST_TM-1:0] tm;
        logic [WID_INST_TN-1:0] tn;
    } inst_t;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        LOAD,
        COMP,
        WB
    } state_t;

    // A zero field would mean an empty loop; the block treats it as one pass.
    function automatic inst_t fill_zero(inst_t i);
        inst_t o;
        o = i;
        if (i.tn == '0) o.tn = WID_INST_TN'(1);
        if (i.tm == '0) o.tm = WID_INST_TM'(1);
        if (i.tp == '0) o.tp = WID_INST_TP'(1);
        if (i.ln == '0) o.ln = WID_INST_LN'(1);
        if (i.lp == '0) o.lp = WID_INST_LP'(1);
        return o;
    endfunction

    function automatic logic [WID_NB-1:0] beats_of(inst_t i);
        return WID_NB'(i.tn) * WID_NB'(i.tp) * WID_NB'(N_TILE);
    endfunction

    function automatic logic [WID_NCOMP-1:0] comp_of(inst_t i);
        return WID_NCOMP'(i.tm) * WID_NCOMP'(i.tp);
    endfunction

endpackage

// File: rtl/sblk_if.sv
// ----------------------------------------------------------------------------
// sblk_if
//   Bundle of the sequencer's dispatcher-side and stream-side signals.
//     inst_data/inst_en            : packed loop instruction and its strobe
//     act_data_in_vld/act_data_in  : activation beat stream into the block
//     act_data_in_req              : one-cycle request for one activation tile
//     status_sblk                  : block busy executing an instruction
//     pe_act_data/pe_act_vld       : registered buffer read feeding the PE array
//   modport slave  : the sblk sequencer side
//   modport master : dispatcher / activation source / PE array side
// ----------------------------------------------------------------------------
interface sblk_if;
    import sblk_pkg::*;

    logic [WID_INST-1:0]  inst_data;
    logic                 inst_en;
    logic                 act_data_in_vld;
    logic [2*WID_ACT-1:0] act_data_in;
    logic                 act_data_in_req;
    logic                 status_sblk;
    logic [2*WID_ACT-1:0] pe_act_data;
    logic                 pe_act_vld;

    modport slave (
        input  inst_data, inst_en, act_data_in_vld, act_data_in,
        output act_data_in_req, status_sblk, pe_act_data, pe_act_vld
    );

    modport master (
        output inst_data, inst_en, act_data_in_vld, act_data_in,
        input  act_data_in_req, status_sblk, pe_act_data, pe_act_vld
    );

endinterface

// File: rtl/sblk_act_buf.sv
// ----------------------------------------------------------------------------
// sblk_act_buf
//   Simple dual-port activation buffer, 2**ADDR_W words of DATA_W bits.
//     clk      : clock
//     wr_en    : write strobe (beats arriving during LOAD)
//     wr_addr  : write address
//     wr_data  : write data (one activation beat, two words)
//     rd_en    : read strobe (COMP cycles)
//     rd_addr  : read address
//     rd_data  : registered read data, valid the cycle after rd_en
//   Contents are not reset; the sequencer never reads an address before it has
//   been loaded within the same iteration.
// ----------------------------------------------------------------------------
module sblk_act_buf #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_q;

    // Write and registered read share the clock; LOAD and COMP never overlap,
    // so read-during-write ordering does not matter here.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sblk_ctrl.sv
// ----------------------------------------------------------------------------
// sblk_ctrl
//   Control sequencer of one systolic block. Latches a loop instruction,
//   runs n_lp x n_ln iterations of {request tile, load beats, compute}, then
//   drains write-back for WB_DELAY_CYCLE cycles before dropping busy.
//     clk_l : clock, all logic on posedge
//     rst   : asynchronous active-high reset
//     bus   : sblk_if.slave (instruction, activation stream, status, PE feed)
// ----------------------------------------------------------------------------
module sblk_ctrl
    import sblk_pkg::*;
(
    input  logic  clk_l,
    input  logic  rst,
    sblk_if.slave bus
);

    state_t                 state_q, state_d;
    inst_t                  inst_q, inst_d;
    logic [WID_INST_LP-1:0] lp_q, lp_d;
    logic [WID_INST_LN-1:0] ln_q, ln_d;
    logic [WID_NB-1:0]      wcnt_q, wcnt_d;
    logic [WID_NB-1:0]      rcnt_q, rcnt_d;
    logic [WID_NCOMP-1:0]   ccnt_q, ccnt_d;
    logic [WID_WB-1:0]      wb_q, wb_d;
    logic                   req_q, req_d;
    logic                   status_q, status_d;
    logic                   pe_vld_q, pe_vld_d;

    logic                   buf_wr_en;
    logic                   buf_rd_en;
    logic [WID_NB-1:0]      nb;
    logic [WID_NCOMP-1:0]   ncomp;

    assign nb    = beats_of(inst_q);
    assign ncomp = comp_of(inst_q);

    // Next-state logic for the loop sequencer. rcnt walks the read address
    // modulo the beat count so a compute phase longer than the tile simply
    // re-reads it; the buffer index itself wraps modulo the buffer depth.
    // req/status/pe_vld are derived from the next state so they come out of
    // flops aligned with the state they describe.
    always_comb begin
        state_d   = state_q;
        inst_d    = inst_q;
        lp_d      = lp_q;
        ln_d      = ln_q;
        wcnt_d    = wcnt_q;
        rcnt_d    = rcnt_q;
        ccnt_d    = ccnt_q;
        wb_d      = wb_q;
        buf_wr_en = 1'b0;
        buf_rd_en = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.inst_en) begin
                    inst_d  = fill_zero(inst_t'(bus.inst_data));
                    lp_d    = '0;
                    ln_d    = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                wcnt_d  = '0;
                state_d = LOAD;
            end
            LOAD: begin
                if (bus.act_data_in_vld) begin
                    buf_wr_en = 1'b1;
                    wcnt_d    = wcnt_q + WID_NB'(1);
                    if (wcnt_q == nb - WID_NB'(1)) begin
                        ccnt_d  = '0;
                        rcnt_d  = '0;
                        state_d = COMP;
                    end
                end
            end
            COMP: begin
                buf_rd_en = 1'b1;
                ccnt_d    = ccnt_q + WID_NCOMP'(1);
                rcnt_d    = (rcnt_q == nb - WID_NB'(1)) ? '0 : rcnt_q + WID_NB'(1);
                if (ccnt_q == ncomp - WID_NCOMP'(1)) begin
                    if (ln_q != inst_q.ln - WID_INST_LN'(1)) begin
                        ln_d    = ln_q + WID_INST_LN'(1);
                        state_d = REQ;
                    end else if (lp_q != inst_q.lp - WID_INST_LP'(1)) begin
                        ln_d    = '0;
                        lp_d    = lp_q + WID_INST_LP'(1);
                        state_d = REQ;
                    end else begin
                        wb_d    = '0;
                        state_d = WB;
                    end
                end
            end
            WB: begin
                wb_d = wb_q + WID_WB'(1);
                if (wb_q == WID_WB'(WB_DELAY_CYCLE - 1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_d    = (state_d == REQ);
        status_d = (state_d != IDLE);
        pe_vld_d = buf_rd_en;
    end

    // Single register bank for state, counters and registered outputs; an
    // asserted reset aborts any instruction in flight.
    always_ff @(posedge clk_l or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            inst_q   <= '0;
            lp_q     <= '0;
            ln_q     <= '0;
            wcnt_q   <= '0;
            rcnt_q   <= '0;
            ccnt_q   <= '0;
            wb_q     <= '0;
            req_q    <= 1'b0;
            status_q <= 1'b0;
            pe_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            inst_q   <= inst_d;
            lp_q     <= lp_d;
            ln_q     <= ln_d;
            wcnt_q   <= wcnt_d;
            rcnt_q   <= rcnt_d;
            ccnt_q   <= ccnt_d;
            wb_q     <= wb_d;
            req_q    <= req_d;
            status_q <= status_d;
            pe_vld_q <= pe_vld_d;
        end
    end

    sblk_act_buf #(
        .ADDR_W (WID_ACTADDR),
        .DATA_W (2 * WID_ACT)
    ) u_act_buf (
        .clk     (clk_l),
        .wr_en   (buf_wr_en),
        .wr_addr (wcnt_q[WID_ACTADDR-1:0]),
        .wr_data (bus.act_data_in),
        .rd_en   (buf_rd_en),
        .rd_addr (rcnt_q[WID_ACTADDR-1:0]),
        .rd_data (bus.pe_act_data)
    );

    assign bus.act_data_in_req = req_q;
    assign bus.status_sblk     = status_q;
    assign bus.pe_act_vld      = pe_vld_q;

endmodule

// File: tb/tb_sblk_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sblk_ctrl
//   Self-checking bench for sblk_ctrl. Each instruction is turned into an
//   expected cycle-by-cycle trace (request, busy, PE feed) built from the loop
//   rules with plain arithmetic, while the same trace carries the stimulus:
//   activation beats with optional gaps plus stray valids and instruction
//   strobes outside the windows where they should count.
// ----------------------------------------------------------------------------
module tb_sblk_ctrl;
    import sblk_pkg::*;

    localparam int MAXC  = 8192;
    localparam int DEPTH = 64;
    localparam int WB_N  = 12;
    localparam int TILES = 4;

    logic clk_l = 1'b0;
    logic rst;

    always #5 clk_l = ~clk_l;

    sblk_if bus_if ();

    sblk_ctrl u_dut (
        .clk_l (clk_l),
        .rst   (rst),
        .bus   (bus_if)
    );

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Expected trace and stimulus, indexed by cycle after instruction accept.
    bit          exp_req  [MAXC];
    bit          exp_stat [MAXC];
    bit          exp_pv   [MAXC];
    logic [31:0] exp_pd   [MAXC];
    bit          drv_vld  [MAXC];
    logic [31:0] drv_dat  [MAXC];
    bit          drv_en   [MAXC];
    logic [27:0] drv_inst [MAXC];
    logic [31:0] mem_model [DEPTH];

    int          n_cyc;
    int          exp_reqs;
    logic [27:0] cur_inst;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int k);
        bus_if.act_data_in_vld = drv_vld[k];
        bus_if.act_data_in     = drv_dat[k];
        bus_if.inst_en         = drv_en[k];
        bus_if.inst_data       = drv_inst[k];
    endtask

    // One cycle of the trace; stray valids/strobes only where they must be ignored.
    task automatic setCycle(input int k, input bit busy, input bit noise);
        if (k >= MAXC - 2) begin
            $display("[TB] FAIL trace_overflow observed=%0d required<%0d", k, MAXC - 2);
            $fatal(1, "[TB] trace overflow");
        end
        exp_req[k]  = 1'b0;
        exp_stat[k] = busy;
        drv_vld[k]  = noise ? 1'($urandom_range(1)) : 1'b0;
        drv_dat[k]  = $urandom;
        drv_en[k]   = busy && ($urandom_range(9) == 0);
        drv_inst[k] = 28'($urandom);
    endtask

    task automatic buildTimeline(input int tn, input int tm, input int tp,
                                 input int ln, input int lp, input int gap_pct,
                                 input bit pattern, input int tail);
        int e_tn, e_tm, e_tp, e_ln, e_lp, nb, nc, k, w;
        e_tn = (tn == 0) ? 1 : tn;
        e_tm = (tm == 0) ? 1 : tm;
        e_tp = (tp == 0) ? 1 : tp;
        e_ln = (ln == 0) ? 1 : ln;
        e_lp = (lp == 0) ? 1 : lp;
        nb = e_tn * e_tp * TILES;
        nc = e_tm * e_tp;
        exp_reqs = e_ln * e_lp;
        cur_inst = {5'(lp), 5'(ln), 5'(tp), 9'(tm), 4'(tn)};
        for (int i = 0; i < MAXC; i++) begin
            exp_pv[i] = 1'b0;
            exp_pd[i] = '0;
        end
        k = 1;
        for (int it = 0; it < exp_reqs; it++) begin
            setCycle(k, 1'b1, 1'b1);
            exp_req[k] = 1'b1;
            k++;
            w = 0;
            while (w < nb) begin
                setCycle(k, 1'b1, 1'b0);
                if (int'($urandom_range(99)) >= gap_pct) begin
                    drv_vld[k] = 1'b1;
                    if (pattern) drv_dat[k] = {16'(2 * w + 1), 16'(2 * w)};
                    mem_model[w % DEPTH] = drv_dat[k];
                    w++;
                end
                k++;
            end
            for (int c = 0; c < nc; c++) begin
                setCycle(k, 1'b1, 1'b1);
                exp_pv[k + 1] = 1'b1;
                exp_pd[k + 1] = mem_model[(c % nb) % DEPTH];
                k++;
            end
        end
        for (int i = 0; i < WB_N; i++) begin
            setCycle(k, 1'b1, 1'b1);
            k++;
        end
        for (int i = 0; i < tail; i++) begin
            setCycle(k, 1'b0, 1'b1);
            k++;
        end
        n_cyc = k - 1;
    endtask

    // Called at a negedge; the instruction strobe is sampled at the next posedge.
    task automatic runTimeline(input int limit);
        int last, req_seen;
        last = (limit < n_cyc) ? limit : n_cyc;
        req_seen = 0;
        bus_if.inst_en         = 1'b1;
        bus_if.inst_data       = cur_inst;
        bus_if.act_data_in_vld = 1'b0;
        @(posedge clk_l);
        for (int k = 1; k <= last; k++) begin
            @(negedge clk_l);
            checkOutput($sformatf("req@%0d", k), 32'(bus_if.act_data_in_req), 32'(exp_req[k]));
            checkOutput($sformatf("status@%0d", k), 32'(bus_if.status_sblk), 32'(exp_stat[k]));
            checkOutput($sformatf("pe_vld@%0d", k), 32'(bus_if.pe_act_vld), 32'(exp_pv[k]));
            if (exp_pv[k]) begin
                checkOutput($sformatf("pe_data@%0d", k), bus_if.pe_act_data, exp_pd[k]);
            end
            if (bus_if.act_data_in_req === 1'b1) req_seen++;
            applyStimulus(k);
        end
        if (last == n_cyc) begin
            checkOutput("req_count", 32'(req_seen), 32'(exp_reqs));
        end
    endtask

    task automatic idleCycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_l);
            checkOutput($sformatf("%s_req", tag), 32'(bus_if.act_data_in_req), 32'd0);
            checkOutput($sformatf("%s_status", tag), 32'(bus_if.status_sblk), 32'd0);
            bus_if.act_data_in_vld = 1'($urandom_range(1));
            bus_if.act_data_in     = $urandom;
            bus_if.inst_en         = 1'b0;
            bus_if.inst_data       = 28'($urandom);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst                    = 1'b1;
        bus_if.inst_en         = 1'b0;
        bus_if.inst_data       = '0;
        bus_if.act_data_in_vld = 1'b0;
        bus_if.act_data_in     = '0;

        // Reset held 20 cycles while inputs toggle.
        $display("[TB] reset hold");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_l);
            checkOutput("rst_req", 32'(bus_if.act_data_in_req), 32'd0);
            checkOutput("rst_status", 32'(bus_if.status_sblk), 32'd0);
            checkOutput("rst_pe_vld", 32'(bus_if.pe_act_vld), 32'd0);
            bus_if.inst_en         = 1'($urandom_range(1));
            bus_if.inst_data       = 28'($urandom);
            bus_if.act_data_in_vld = 1'($urandom_range(1));
            bus_if.act_data_in     = $urandom;
        end
        rst = 1'b0;
        bus_if.inst_en = 1'b0;
        idleCycles(3, "post_rst");

        // tp=2 tm=6 tn=2 ln=2 lp=2, contiguous beats; next instruction on status fall.
        $display("[TB] instruction A");
        buildTimeline(2, 6, 2, 2, 2, 0, 1'b0, 1);
        runTimeline(MAXC);
        $display("[TB] instruction B issued on status fall");
        buildTimeline(2, 2, 3, 2, 2, 0, 1'b0, 3);
        runTimeline(MAXC);

        // Gapped beats with a recognisable pattern, read back through the PE feed.
        $display("[TB] gapped load pattern");
        buildTimeline(2, 8, 2, 1, 1, 40, 1'b1, 2);
        runTimeline(MAXC);

        // All-zero fields behave as all-ones.
        $display("[TB] zero instruction");
        buildTimeline(0, 0, 0, 0, 0, 0, 1'b0, 2);
        runTimeline(MAXC);

        // Beat count beyond buffer depth: addresses wrap, later beats overwrite.
        $display("[TB] wrap");
        buildTimeline(5, 30, 4, 1, 1, 20, 1'b0, 2);
        runTimeline(MAXC);

        $display("[TB] random instructions");
        for (int r = 0; r < 6; r++) begin
            buildTimeline(int'($urandom_range(3)), int'($urandom_range(7)),
                          int'($urandom_range(3)), int'($urandom_range(2)),
                          int'($urandom_range(2)), int'($urandom_range(50)),
                          1'b0, 2);
            runTimeline(MAXC);
        end

        // Reset asserted mid-LOAD aborts the instruction.
        $display("[TB] reset during load");
        buildTimeline(2, 6, 2, 2, 2, 0, 1'b0, 1);
        runTimeline(6);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abort_req", 32'(bus_if.act_data_in_req), 32'd0);
        checkOutput("abort_status", 32'(bus_if.status_sblk), 32'd0);
        checkOutput("abort_pe_vld", 32'(bus_if.pe_act_vld), 32'd0);
        repeat (3) @(negedge clk_l);
        rst = 1'b0;
        bus_if.inst_en = 1'b0;
        idleCycles(40, "after_abort");

        $display("[TB] instruction after abort");
        buildTimeline(1, 3, 2, 1, 2, 10, 1'b0, 2);
        runTimeline(MAXC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
